// File: rtl/sobel_window_gen.sv
// -----------------------------------------------------------------------------
// sobel_window_gen
//
// Purpose:
//   Builds a sliding 3x3 pixel window from a raster-order pixel stream for a
//   downstream Sobel (or any 3x3) kernel. Two line delays supply the two
//   previous lines, and a 3x3 register window shifts left on every accepted
//   pixel. A window is flagged valid only when it lies entirely inside the
//   current frame, so it never straddles a line or frame boundary.
//
// Parameters:
//   IMG_WIDTH   pixels per line  (>= 3)
//   IMG_HEIGHT  lines per frame  (>= 3)
//
// Ports:
//   clk          single clock, rising edge
//   rst          asynchronous, active-high reset
//   we_i         pixel strobe; data_i accepted on each rising edge with we_i=1
//   data_i       8-bit raster-order pixel
//   win_valid_o  window_o holds a valid 3x3 window this cycle
//   window_o     {p00,p01,p02,p10,p11,p12,p20,p21,p22}, p00 = top-left
//                (oldest) at [71:64], p22 = current pixel at [7:0]
//   done_o       one-cycle pulse after the last pixel of a frame
//   frame_cnt_o  (FRAME_COUNT_EN only) 16-bit count of completed frames
//
// Configuration:
//   FRAME_COUNT_EN  when defined, adds frame_cnt_o and its counter.
//
// Handshake: there is no backpressure. A pixel is transferred on every rising
// edge where we_i=1; win_valid_o and done_o are single-cycle, registered
// qualifiers of the pixel accepted on the previous edge.
// -----------------------------------------------------------------------------
module sobel_window_gen #(
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [7:0]  data_i,
    output logic        win_valid_o,
    output logic [71:0] window_o,
    output logic        done_o
`ifdef FRAME_COUNT_EN
    ,
    output logic [15:0] frame_cnt_o
`endif
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    logic [CW-1:0] col;
    logic [RW-1:0] row;

    // Line delays are circular buffers addressed by the column counter: the
    // entry at [col] was written exactly one line ago at the same column.
    logic [7:0] line1_mem [IMG_WIDTH];
    logic [7:0] line0_mem [IMG_WIDTH];
    logic [7:0] line1_out;
    logic [7:0] line0_out;

    logic [7:0] win [3][3];

    logic at_last_col;
    logic at_last_row;
    logic in_window;

    assign line1_out   = line1_mem[col];
    assign line0_out   = line0_mem[col];
    assign at_last_col = (col == COL_LAST);
    assign at_last_row = (row == ROW_LAST);
    // Gating on the position of the incoming pixel: col>=2 keeps the window
    // inside one line, row>=2 keeps stale previous-frame lines out of it.
    assign in_window   = (col >= COL_TWO) && (row >= ROW_TWO);

    assign window_o = {win[0][0], win[0][1], win[0][2],
                       win[1][0], win[1][1], win[1][2],
                       win[2][0], win[2][1], win[2][2]};

    // Line-delay storage carries no reset; its contents are never marked
    // valid until two fresh lines have been written.
    always_ff @(posedge clk) begin
        if (we_i) begin
            line1_mem[col] <= data_i;
            line0_mem[col] <= line1_out;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col         <= '0;
            row         <= '0;
            win_valid_o <= 1'b0;
            done_o      <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
`ifdef FRAME_COUNT_EN
            frame_cnt_o <= '0;
`endif
        end else begin
            win_valid_o <= we_i && in_window;
            done_o      <= we_i && at_last_col && at_last_row;

            if (we_i) begin
                if (at_last_col) begin
                    col <= '0;
                    row <= at_last_row ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end

                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                end
                win[0][2] <= line0_out;
                win[1][2] <= line1_out;
                win[2][2] <= data_i;

`ifdef FRAME_COUNT_EN
                if (at_last_col && at_last_row) begin
                    frame_cnt_o <= frame_cnt_o + 16'd1;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_sobel_window_gen.sv
// -----------------------------------------------------------------------------
// tb_sobel_window_gen
//
// Testbench for sobel_window_gen at default size (8x8). Vectors are records of
// {we, data, expected valid/done/window}; each record is applied for one
// clock and its expectations are compared 1 time unit after that edge.
// Expected windows are computed from pixel coordinates: for a pixel at
// (r,c) with value base + r*8 + c, the window holds the 3x3 block whose
// bottom-right corner is that pixel.
// -----------------------------------------------------------------------------
module tb_sobel_window_gen;

    localparam int W = 8;
    localparam int H = 8;

    logic        clk;
    logic        rst;
    logic        we_i;
    logic [7:0]  data_i;
    logic        win_valid_o;
    logic [71:0] window_o;
    logic        done_o;
`ifdef FRAME_COUNT_EN
    logic [15:0] frame_cnt_o;
`endif

    sobel_window_gen #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .we_i        (we_i),
        .data_i      (data_i),
        .win_valid_o (win_valid_o),
        .window_o    (window_o),
        .done_o      (done_o)
`ifdef FRAME_COUNT_EN
        ,
        .frame_cnt_o (frame_cnt_o)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- vectors and scoreboard ----------------
    typedef struct {
        logic        we;
        logic [7:0]  data;
        logic        exp_valid;
        logic        exp_done;
        logic        chk_win;
        logic [71:0] exp_win;
    } vec_t;

    vec_t vecs[$];

    int checks    = 0;
    int failures  = 0;
    int obs_pulses;
    int obs_done;
    logic [71:0] last_done_win;
    int exp_fc = 0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [71:0] exp_window(input int base, input int r, input int c);
        logic [71:0] w;
        w = '0;
        for (int rr = 0; rr < 3; rr++) begin
            for (int cc = 0; cc < 3; cc++) begin
                w = {w[63:0], 8'(base + (r - 2 + rr) * W + (c - 2 + cc))};
            end
        end
        return w;
    endfunction

    // Appends npix pixels of a frame starting at value base; with toggle set,
    // an idle cycle follows each pixel and the window must hold across it.
    task automatic add_frame(input int base, input int npix, input bit toggle);
        vec_t v;
        int   r;
        int   c;
        for (int i = 0; i < npix; i++) begin
            r = i / W;
            c = i % W;
            v.we        = 1'b1;
            v.data      = 8'(base + i);
            v.exp_valid = (r >= 2) && (c >= 2);
            v.exp_done  = (i == W * H - 1);
            v.chk_win   = v.exp_valid;
            v.exp_win   = v.exp_valid ? exp_window(base, r, c) : '0;
            vecs.push_back(v);
            if (toggle) begin
                v.we        = 1'b0;
                v.data      = 8'($urandom_range(0, 255));
                v.exp_valid = 1'b0;
                v.exp_done  = 1'b0;
                vecs.push_back(v);
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic run_table();
        obs_pulses    = 0;
        obs_done      = 0;
        last_done_win = '0;
        for (int i = 0; i < vecs.size(); i++) begin
            we_i   = vecs[i].we;
            data_i = vecs[i].data;
            @(posedge clk);
            #1;
            if (vecs[i].exp_done) exp_fc = (exp_fc + 1) % 65536;
            chk($sformatf("valid[%0d]", i), 72'(win_valid_o), 72'(vecs[i].exp_valid));
            chk($sformatf("done[%0d]", i), 72'(done_o), 72'(vecs[i].exp_done));
            if (vecs[i].chk_win)
                chk($sformatf("window[%0d]", i), window_o, vecs[i].exp_win);
`ifdef FRAME_COUNT_EN
            chk($sformatf("frame_cnt[%0d]", i), 72'(frame_cnt_o), 72'(exp_fc));
`endif
            if (win_valid_o) obs_pulses++;
            if (done_o) begin
                obs_done++;
                last_done_win = window_o;
            end
        end
        we_i = 1'b0;
        vecs.delete();
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_valid"}, 72'(win_valid_o), 72'(0));
        chk({tag, "_done"}, 72'(done_o), 72'(0));
        chk({tag, "_window"}, window_o, 72'(0));
`ifdef FRAME_COUNT_EN
        chk({tag, "_frame_cnt"}, 72'(frame_cnt_o), 72'(0));
`endif
    endtask

    // ---------------- test sequence ----------------
    initial begin
        rst    = 1'b1;
        we_i   = 1'b0;
        data_i = '0;
        #1;
        check_zero_outputs("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Continuous frame 0..63
        add_frame(0, W * H, 1'b0);
        run_table();
        chk("frameA_pulses", 72'(obs_pulses), 72'(36));
        chk("frameA_done_cnt", 72'(obs_done), 72'(1));
        chk("frameA_last_win", last_done_win, exp_window(0, 7, 7));

        // Same frame with we_i toggling; window must hold on idle cycles
        add_frame(0, W * H, 1'b1);
        run_table();
        chk("toggle_pulses", 72'(obs_pulses), 72'(36));
        chk("toggle_last_win", last_done_win, exp_window(0, 7, 7));

        // Two back-to-back frames, second starts at 100
        add_frame(0, W * H, 1'b0);
        add_frame(100, W * H, 1'b0);
        run_table();
        chk("b2b_pulses", 72'(obs_pulses), 72'(72));
        chk("b2b_done_cnt", 72'(obs_done), 72'(2));
        chk("b2b_last_win", last_done_win, exp_window(100, 7, 7));
        chk("b2b_first_win2", exp_window(100, 2, 2),
            {8'd100, 8'd101, 8'd102, 8'd108, 8'd109, 8'd110, 8'd116, 8'd117, 8'd118});

        // Partial frame (pixels 0..30), then asynchronous reset mid-cycle
        add_frame(0, 31, 1'b0);
        run_table();
        chk("pre_reset_valid", 72'(win_valid_o), 72'(1));
        #2;
        rst = 1'b1;
        exp_fc = 0;
        #1;
        check_zero_outputs("async_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Fresh frame after reset behaves like the first one
        add_frame(0, W * H, 1'b0);
        run_table();
        chk("post_reset_pulses", 72'(obs_pulses), 72'(36));
        chk("post_reset_done_cnt", 72'(obs_done), 72'(1));
        chk("post_reset_last_win", last_done_win, exp_window(0, 7, 7));

        // Idle cycle after frame: no pulses
        @(posedge clk);
        #1;
        chk("idle_valid", 72'(win_valid_o), 72'(0));
        chk("idle_done", 72'(done_o), 72'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
